apb_mem_bridge: RTL and testbench

- APB (v3-style) slave that turns single APB transfers into the 16-word memory request/ready handshake consumed directly downstream by the simple memory interface.
- Holds the memory request until the memory's random-latency ready, then completes the APB access phase with registered read data.
- Flags bad addresses and stalled memory on pslverr.
- Sits between the APB arbiter/interconnect and the memory.

---
 rtl/apb_mem_pkg.sv | 18 +
 rtl/bridge_timeout_ctr.sv | 28 ++
 rtl/apb_mem_bridge.sv | 121 ++++++++++++
 tb/tb_apb_mem_bridge.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB-to-memory bridge.
package apb_mem_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StResp} bridge_state_e;

  localparam int unsigned MEM_WORDS = 16;
  localparam int unsigned MEM_IDX_W = 4;
  localparam int unsigned DATA_W    = 32;

  // Window hit: upper bits match the base (64-byte window) and the address is word aligned.
  function automatic logic addr_hit(input logic [63:0] addr, input logic [63:0] base,
                                    input int unsigned addr_w);
    logic [63:0] mask;
    mask = ((64'h1 << addr_w) - 64'h1) & ~64'h3f;
    return (((addr ^ base) & mask) == 64'h0) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Cycle counter for the REQ state; flags the last permitted cycle before abort.
module bridge_timeout_ctr #(
  parameter int unsigned TIMEOUT = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_mem_bridge.sv
// APB slave converting single transfers into a held request/ready memory handshake.
module apb_mem_bridge
  import apb_mem_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        TIMEOUT   = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [ADDR_W-1:0]    paddr_i,
  input  logic [DATA_W-1:0]    pwdata_i,
  output logic                 pready_o,
  output logic [DATA_W-1:0]    prdata_o,
  output logic                 pslverr_o,
  output logic                 mem_req_o,
  output logic                 mem_rnw_o,
  output logic [MEM_IDX_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic                 mem_ready_i,
  input  logic [DATA_W-1:0]    mem_rdata_i
);

  bridge_state_e        state, state_next;
  logic                 pready_next, pslverr_next, req_next, rnw_next;
  logic [DATA_W-1:0]    prdata_next, wdata_next;
  logic [MEM_IDX_W-1:0] addr_next;
  logic                 ctr_clr, ctr_en, expired, hit;

  assign hit = addr_hit(64'(paddr_i), 64'(BASE_ADDR), ADDR_W);

  bridge_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  always_comb begin
    state_next   = state;
    pready_next  = 1'b0;
    pslverr_next = 1'b0;
    req_next     = 1'b0;
    prdata_next  = prdata_o;
    rnw_next     = mem_rnw_o;
    addr_next    = mem_addr_o;
    wdata_next   = mem_wdata_o;
    ctr_clr      = 1'b0;
    ctr_en       = 1'b0;
    unique case (state)
      StIdle: begin
        // An access phase arriving in IDLE has no setup and is dropped.
        if (psel_i && !penable_i) begin
          rnw_next   = ~pwrite_i;
          addr_next  = paddr_i[5:2];
          wdata_next = pwdata_i;
          if (hit) begin
            state_next = StReq;
            req_next   = 1'b1;
            ctr_clr    = 1'b1;
          end else begin
            state_next   = StResp;
            pready_next  = 1'b1;
            pslverr_next = 1'b1;
            prdata_next  = '0;
          end
        end
      end
      StReq: begin
        ctr_en = 1'b1;
        if (mem_ready_i) begin
          state_next  = StResp;
          pready_next = 1'b1;
          prdata_next = mem_rnw_o ? mem_rdata_i : '0;
        end else if (expired) begin
          state_next   = StResp;
          pready_next  = 1'b1;
          pslverr_next = 1'b1;
          prdata_next  = '0;
        end else begin
          req_next = 1'b1;
        end
      end
      StResp: begin
        state_next = StIdle;
      end
      default: begin
        state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      pready_o    <= 1'b0;
      pslverr_o   <= 1'b0;
      prdata_o    <= '0;
      mem_req_o   <= 1'b0;
      mem_rnw_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state       <= state_next;
      pready_o    <= pready_next;
      pslverr_o   <= pslverr_next;
      prdata_o    <= prdata_next;
      mem_req_o   <= req_next;
      mem_rnw_o   <= rnw_next;
      mem_addr_o  <= addr_next;
      mem_wdata_o <= wdata_next;
    end
  end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Directed self-checking bench for apb_mem_bridge with a latency-programmable memory stub.
module tb_apb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        pready_o, pslverr_o, mem_req_o, mem_rnw_o, mem_ready_i;
  logic [31:0] prdata_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_addr_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory stub: ready after ready_lat REQ cycles (0 = never), or always when ready_tie.
  logic        ready_tie = 1'b0;
  int          ready_lat = 2;
  int          req_cyc = 0;
  logic [31:0] mem [16];

  assign mem_ready_i = ready_tie |
                       (mem_req_o && (ready_lat != 0) && (req_cyc == ready_lat - 1));
  assign mem_rdata_i = mem[mem_addr_o];

  always @(posedge clk) begin
    req_cyc <= mem_req_o ? req_cyc + 1 : 0;
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'(i) * 32'h1111_1111;
    end else if (mem_req_o && mem_ready_i && !mem_rnw_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
    end
  end

  // Request-edge and pready-cycle monitor.
  logic mon_clr = 1'b0;
  logic prev_req = 1'b0;
  int   rises = 0, min_gap = 1000, low_run = 1000, pready_cyc = 0;

  always @(negedge clk) begin
    prev_req <= mem_req_o;
    if (mon_clr) begin
      rises <= 0; min_gap <= 1000; low_run <= 1000; pready_cyc <= 0;
    end else begin
      if (pready_o) pready_cyc <= pready_cyc + 1;
      if (mem_req_o) begin
        if (!prev_req) begin
          rises <= rises + 1;
          if (low_run < min_gap) min_gap <= low_run;
        end
        low_run <= 0;
      end else begin
        low_run <= low_run + 1;
      end
    end
  end

  apb_mem_bridge #(
    .ADDR_W    (32),
    .BASE_ADDR (32'h0000_0000),
    .TIMEOUT   (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .pready_o    (pready_o),
    .prdata_o    (prdata_o),
    .pslverr_o   (pslverr_o),
    .mem_req_o   (mem_req_o),
    .mem_rnw_o   (mem_rnw_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Results of the most recent transfer.
  int          x_lat, x_req_hi;
  logic [31:0] x_rd;
  logic        x_err, x_rnw;
  logic [3:0]  x_addr;

  // Called just after a rising edge; that cycle becomes the setup phase.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    x_lat = 0; x_req_hi = 0; x_addr = 'x; x_rnw = 'x; x_rd = 'x; x_err = 'x;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (mem_req_o) begin
        if (x_req_hi == 0) begin
          x_addr = mem_addr_o;
          x_rnw  = mem_rnw_o;
        end
        x_req_hi++;
      end
      if (pready_o) begin
        x_lat = c; x_rd = prdata_o; x_err = pslverr_o;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (x_lat == 0) begin
      n_bad++;
      $display("FAIL xfer_bound addr=%h: no pready within 60 cycles, required completion", addr);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({pready_o, pslverr_o, prdata_o, mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o} !== '0)
    begin
      n_bad++;
      $display("FAIL reset_outputs: got pready=%b err=%b rd=%h req=%b rnw=%b addr=%h wd=%h, want 0",
               pready_o, pslverr_o, prdata_o, mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_write_read();
    ready_tie = 1'b0; ready_lat = 3;
    apb_xfer(1'b1, 32'h14, 32'hDEAD_BEEF);
    n_cmp++; if (x_lat !== 4) begin n_bad++; $display("FAIL wr_latency: got %0d want 4", x_lat); end
    n_cmp++; if (x_addr !== 4'd5) begin n_bad++; $display("FAIL wr_addr: got %0d want 5", x_addr); end
    n_cmp++; if (x_rnw !== 1'b0) begin n_bad++; $display("FAIL wr_rnw: got %b want 0", x_rnw); end
    n_cmp++; if (x_err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", x_err); end
    apb_xfer(1'b0, 32'h14, 32'h0);
    n_cmp++; if (x_lat !== 4) begin n_bad++; $display("FAIL rd_latency: got %0d want 4", x_lat); end
    n_cmp++; if (x_addr !== 4'd5) begin n_bad++; $display("FAIL rd_addr: got %0d want 5", x_addr); end
    n_cmp++; if (x_rnw !== 1'b1) begin n_bad++; $display("FAIL rd_rnw: got %b want 1", x_rnw); end
    n_cmp++;
    if (x_rd !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL rd_data: got %h want deadbeef", x_rd);
    end
    n_cmp++; if (x_err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", x_err); end
  endtask

  task automatic test_immediate_ready();
    ready_tie = 1'b1;
    apb_xfer(1'b1, 32'h3C, 32'hA5A5_0F0F);
    apb_xfer(1'b0, 32'h3C, 32'h0);
    n_cmp++; if (x_req_hi !== 1) begin n_bad++; $display("FAIL imm_req_cycles: got %0d want 1", x_req_hi); end
    n_cmp++; if (x_lat !== 2) begin n_bad++; $display("FAIL imm_latency: got %0d want 2", x_lat); end
    n_cmp++; if (x_addr !== 4'd15) begin n_bad++; $display("FAIL imm_addr: got %0d want 15", x_addr); end
    n_cmp++;
    if (x_rd !== 32'hA5A5_0F0F) begin
      n_bad++; $display("FAIL imm_data: got %h want a5a50f0f", x_rd);
    end
    ready_tie = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [3];
    ready_tie = 1'b0; ready_lat = 2;
    mon_clr = 1'b1; @(negedge clk); #1 mon_clr = 1'b0;
    @(posedge clk); #1;
    apb_xfer(1'b0, 32'h00, 32'h0); rd[0] = x_rd;
    apb_xfer(1'b0, 32'h04, 32'h0); rd[1] = x_rd;
    apb_xfer(1'b0, 32'h08, 32'h0); rd[2] = x_rd;
    @(negedge clk);
    n_cmp++; if (rises !== 3) begin n_bad++; $display("FAIL b2b_rises: got %0d want 3", rises); end
    n_cmp++; if (min_gap < 2) begin n_bad++; $display("FAIL b2b_gap: got %0d want >=2", min_gap); end
    n_cmp++;
    if (pready_cyc !== 3) begin n_bad++; $display("FAIL b2b_pready: got %0d want 3", pready_cyc); end
    n_cmp++;
    if ({rd[0], rd[1], rd[2]} !== {32'h0, 32'h1111_1111, 32'h2222_2222}) begin
      n_bad++; $display("FAIL b2b_data: got %h %h %h want 0 11111111 22222222", rd[0], rd[1], rd[2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    ready_tie = 1'b1;
    apb_xfer(1'b0, 32'h42, 32'h0);
    n_cmp++; if (x_req_hi !== 0) begin n_bad++; $display("FAIL oow_req: got %0d want 0", x_req_hi); end
    n_cmp++; if (x_lat !== 1) begin n_bad++; $display("FAIL oow_latency: got %0d want 1", x_lat); end
    n_cmp++; if (x_err !== 1'b1) begin n_bad++; $display("FAIL oow_err: got %b want 1", x_err); end
    n_cmp++; if (x_rd !== 32'h0) begin n_bad++; $display("FAIL oow_data: got %h want 0", x_rd); end
    apb_xfer(1'b1, 32'h06, 32'hFFFF_FFFF);
    n_cmp++; if (x_req_hi !== 0) begin n_bad++; $display("FAIL misal_req: got %0d want 0", x_req_hi); end
    n_cmp++; if (x_lat !== 1) begin n_bad++; $display("FAIL misal_latency: got %0d want 1", x_lat); end
    n_cmp++; if (x_err !== 1'b1) begin n_bad++; $display("FAIL misal_err: got %b want 1", x_err); end
    n_cmp++; if (x_rd !== 32'h0) begin n_bad++; $display("FAIL misal_data: got %h want 0", x_rd); end
    ready_tie = 1'b0;
  endtask

  task automatic test_timeout();
    ready_tie = 1'b0; ready_lat = 0;
    apb_xfer(1'b0, 32'h10, 32'h0);
    n_cmp++; if (x_req_hi !== 20) begin n_bad++; $display("FAIL to_req_cycles: got %0d want 20", x_req_hi); end
    n_cmp++; if (x_lat !== 21) begin n_bad++; $display("FAIL to_latency: got %0d want 21", x_lat); end
    n_cmp++; if (x_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", x_err); end
    n_cmp++; if (x_rd !== 32'h0) begin n_bad++; $display("FAIL to_data: got %h want 0", x_rd); end
    ready_lat = 2;
    apb_xfer(1'b0, 32'h10, 32'h0);
    n_cmp++; if (x_err !== 1'b0) begin n_bad++; $display("FAIL to_next_err: got %b want 0", x_err); end
    n_cmp++;
    if (x_rd !== 32'h4444_4444) begin
      n_bad++; $display("FAIL to_next_data: got %h want 44444444", x_rd);
    end
  endtask

  task automatic test_reset_mid_req();
    int seen;
    ready_tie = 1'b0; ready_lat = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20; pwdata = 32'h0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req: got %b want 1", mem_req_o); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({pready_o, pslverr_o, prdata_o, mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o} !== '0)
    begin
      n_bad++;
      $display("FAIL rst_async: got pready=%b err=%b rd=%h req=%b rnw=%b addr=%h wd=%h, want 0",
               pready_o, pslverr_o, prdata_o, mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o);
    end
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (pready_o || mem_req_o) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL rst_no_resp: got %0d active cycles want 0", seen); end
    @(posedge clk); #1;
    ready_lat = 2;
    apb_xfer(1'b1, 32'h20, 32'h1234_5678);
    apb_xfer(1'b0, 32'h20, 32'h0);
    n_cmp++; if (x_err !== 1'b0) begin n_bad++; $display("FAIL rst_after_err: got %b want 0", x_err); end
    n_cmp++;
    if (x_rd !== 32'h1234_5678) begin
      n_bad++; $display("FAIL rst_after_data: got %h want 12345678", x_rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_immediate_ready();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
